uart_rx_buffer: RTL and testbench

//  Receive-side partner of the UART transmit stage: deserialises an 8N1 async serial line into bytes.

---
 rtl/uart_rx_buffer.sv | 143 ++++++++++++++
 tb/tb_uart_rx_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// UART receiver: 2-flop synchronised 8N1 deserialiser with mid-bit sampling and registered pulses.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_buffer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic          frame_good;

  // The line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous stage's old value;
      // blocking ones here would collapse the three stages into a single wire.
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  assign frame_good = rx_s && ~^{shift, parity_bit};
`else
  assign frame_good = rx_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      counter       <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      // NOTE: pulses default low every cycle, so each set below lasts exactly one clock.
      valid         <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        S_IDLE: begin
          counter <= '0;
          if (rx_prev && !rx_s) state <= S_START;
        end
        S_START: begin
          if (counter == HALF_LAST) begin
            counter <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end
        S_DATA: begin
          if (counter == BIT_LAST) begin
            counter        <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (counter == BIT_LAST) begin
            counter    <= '0;
            parity_bit <= rx_s;
            state      <= S_STOP;
          end else begin
            counter <= counter + CW'(1);
          end
        end
`endif
        S_STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
          if (counter == BIT_LAST) begin
            counter <= '0;
            state   <= S_IDLE;
            if (frame_good) begin
              data  <= shift;
              valid <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer at 16 clocks/bit; expected values are hand-derived constants.
// Define UART_RX_PARITY_EN to exercise the parity build as well.
module tb_uart_rx_buffer;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // sync (2) + half start bit + remaining full bits up to mid stop + output register
  localparam int LATENCY = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_both = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  logic [7:0] last_valid_data = 8'h00;
  logic [7:0] prev_valid_data = 8'h00;
  int         frame_start_cyc = 0;
`ifdef UART_RX_PARITY_EN
  logic       parity_flip = 1'b0;
`endif

  uart_rx_buffer #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid         <= n_valid + 1;
      prev_valid_cyc  <= last_valid_cyc;
      last_valid_cyc  <= cyc;
      prev_valid_data <= last_valid_data;
      last_valid_data <= data;
    end
    if (framing_error) n_ferr <= n_ferr + 1;
    if (valid && framing_error) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    frame_start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b ^ parity_flip);
`endif
    send_bit(stop);
  endtask

  int v0, f0;

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_ferr", 32'(framing_error), 32'h0);
    reset = 1'b0;
    idle(2 * CPB);

    // 1: clean byte
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b1);
    idle(2 * CPB);
    check("t1_valid_pulses", 32'(n_valid - v0), 32'd1);
    check("t1_data", 32'(data), 32'hA5);
    check("t1_ferr_pulses", 32'(n_ferr - f0), 32'd0);
    check("t1_latency", 32'(last_valid_cyc - frame_start_cyc), 32'(LATENCY));

    // 2: short low glitch is rejected, receiver still usable
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(FRAME_BITS * CPB + 2 * CPB);
    check("t2_valid_pulses", 32'(n_valid - v0), 32'd0);
    check("t2_ferr_pulses", 32'(n_ferr - f0), 32'd0);
    check("t2_data_kept", 32'(data), 32'hA5);
    v0 = n_valid;
    send_frame(8'h5C, 1'b1);
    idle(2 * CPB);
    check("t2_after_valid", 32'(n_valid - v0), 32'd1);
    check("t2_after_data", 32'(data), 32'h5C);

    // 3: stop bit low, line held low afterwards, then a good byte
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("t3_ferr_pulses", 32'(n_ferr - f0), 32'd1);
    check("t3_valid_pulses", 32'(n_valid - v0), 32'd0);
    check("t3_data_kept", 32'(data), 32'h5C);
    idle(FRAME_BITS * CPB + 2 * CPB);
    check("t3_no_rearm_ferr", 32'(n_ferr - f0), 32'd1);
    check("t3_no_rearm_valid", 32'(n_valid - v0), 32'd0);
    send_frame(8'h96, 1'b1);
    idle(2 * CPB);
    check("t3_next_valid", 32'(n_valid - v0), 32'd1);
    check("t3_next_data", 32'(data), 32'h96);

    // 4: back-to-back frames with no idle gap
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * CPB);
    check("t4_valid_pulses", 32'(n_valid - v0), 32'd2);
    check("t4_first_data", 32'(prev_valid_data), 32'h00);
    check("t4_second_data", 32'(last_valid_data), 32'hFF);
    check("t4_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(FRAME_BITS * CPB));
    check("t4_ferr_pulses", 32'(n_ferr - f0), 32'd0);

    // 5: reset in the middle of bit 4 of 8'h5A
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(FRAME_BITS * CPB);
    check("t5_data_cleared", 32'(data), 32'h00);
    check("t5_valid_pulses", 32'(n_valid - v0), 32'd0);
    check("t5_ferr_pulses", 32'(n_ferr - f0), 32'd0);
    send_frame(8'h81, 1'b1);
    idle(2 * CPB);
    check("t5_next_valid", 32'(n_valid - v0), 32'd1);
    check("t5_next_data", 32'(data), 32'h81);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then parity bad
    v0 = n_valid; f0 = n_ferr;
    parity_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    idle(2 * CPB);
    check("t6_good_valid", 32'(n_valid - v0), 32'd1);
    check("t6_good_data", 32'(data), 32'h07);
    check("t6_good_ferr", 32'(n_ferr - f0), 32'd0);
    parity_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    idle(2 * CPB);
    check("t6_bad_ferr", 32'(n_ferr - f0), 32'd1);
    check("t6_bad_valid", 32'(n_valid - v0), 32'd1);
    check("t6_bad_data_kept", 32'(data), 32'h07);
`endif

    check("pulses_exclusive", 32'(n_both), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
